bcd_counter_2dig: RTL

BCD_COUNTER_2DIG -- requirements
Module: bcd_counter_2dig

---
 rtl/bcd_counter_2dig.sv | 100 ++++++++++
 1 files changed

// File: rtl/bcd_counter_2dig.sv
// Two-digit BCD up/down counter with a DIV-cycle prescaler, synchronous load
// with digit validation, a one-cycle wrap pulse and a sticky load-error flag.
module bcd_counter_2dig #(
  parameter int unsigned DIV = 50000000
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       EN,
  input  logic       UP,
  input  logic       LOAD,
  input  logic [7:0] DIN,
  output logic [3:0] BCD_TENS,
  output logic [3:0] BCD_UNITS,
  output logic       TICK,
  output logic       CARRY,
  output logic       LOAD_ERR
);

  localparam logic [25:0] PMax = 26'(DIV - 1);

  logic [25:0] p_q, p_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  units_q, units_d;
  logic        carry_q, carry_d;
  logic        load_err_q, load_err_d;
  logic        din_valid;

  assign din_valid = (DIN[7:4] <= 4'd9) && (DIN[3:0] <= 4'd9);
  assign TICK      = EN && (p_q == PMax) && !LOAD;

  always_comb begin
    p_d        = p_q;
    tens_d     = tens_q;
    units_d    = units_q;
    carry_d    = 1'b0;
    load_err_d = load_err_q;

    if (LOAD) begin
      p_d        = '0;
      load_err_d = !din_valid;
      if (din_valid) begin
        tens_d  = DIN[7:4];
        units_d = DIN[3:0];
      end
    end else begin
      if (EN) begin
        p_d = (p_q == PMax) ? '0 : p_q + 26'd1;
      end
      if (TICK) begin
        if (UP) begin
          if (units_q >= 4'd9) begin
            units_d = 4'd0;
            if (tens_q >= 4'd9) begin
              tens_d  = 4'd0;
              carry_d = 1'b1;
            end else begin
              tens_d = tens_q + 4'd1;
            end
          end else begin
            units_d = units_q + 4'd1;
          end
        end else begin
          if (units_q == 4'd0) begin
            units_d = 4'd9;
            if (tens_q == 4'd0) begin
              tens_d  = 4'd9;
              carry_d = 1'b1;
            end else begin
              tens_d = tens_q - 4'd1;
            end
          end else begin
            units_d = units_q - 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      p_q        <= '0;
      tens_q     <= '0;
      units_q    <= '0;
      carry_q    <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      p_q        <= p_d;
      tens_q     <= tens_d;
      units_q    <= units_d;
      carry_q    <= carry_d;
      load_err_q <= load_err_d;
    end
  end

  assign BCD_TENS  = tens_q;
  assign BCD_UNITS = units_q;
  assign CARRY     = carry_q;
  assign LOAD_ERR  = load_err_q;

endmodule
